// File: rtl/systolic_pe.sv
// Weight-stationary MAC cell: double-buffered weight (shadow/active), one-cycle
// registered multiply-accumulate with optional saturation and sticky overflow.
module systolic_pe #(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 24,
   parameter int SIGNED   = 1,
   parameter int SATURATE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] a_in,
   input  logic [ACC_W-1:0]  acc_in,
   input  logic [DATA_W-1:0] w_in,
   input  logic              load_weight,
   input  logic              swap_weight,
   input  logic              clear_ovf,
   output logic              valid_out,
   output logic [DATA_W-1:0] a_out,
   output logic [ACC_W-1:0]  acc_out,
   output logic [DATA_W-1:0] w_out,
   output logic              ovf
);

   localparam bit P_SIGNED = (SIGNED != 0);
   localparam bit P_SAT    = (SATURATE != 0);

   logic              r_valid;
   logic [DATA_W-1:0] r_a;
   logic [ACC_W-1:0]  r_acc;
   logic [DATA_W-1:0] r_shadow;
   logic [DATA_W-1:0] r_active;
   logic              r_ovf;

   logic              w_a_fill;
   logic              w_wt_fill;
   logic              w_acc_fill;
   logic [ACC_W:0]    w_a_x;
   logic [ACC_W:0]    w_wt_x;
   logic [ACC_W:0]    w_acc_x;
   logic [ACC_W:0]    w_prod_x;
   logic [ACC_W:0]    w_sum;
   logic              w_ovf;
   logic [ACC_W-1:0]  w_sat;
   logic [ACC_W-1:0]  w_result;

   // The true product fits in 2*DATA_W <= ACC_W bits, so multiplying the
   // pre-extended operands modulo 2^(ACC_W+1) yields the extended product.
   assign w_a_fill   = P_SIGNED & a_in[DATA_W-1];
   assign w_wt_fill  = P_SIGNED & r_active[DATA_W-1];
   assign w_acc_fill = P_SIGNED & acc_in[ACC_W-1];
   assign w_a_x      = {{(ACC_W+1-DATA_W){w_a_fill}}, a_in};
   assign w_wt_x     = {{(ACC_W+1-DATA_W){w_wt_fill}}, r_active};
   assign w_acc_x    = {w_acc_fill, acc_in};
   assign w_prod_x   = w_a_x * w_wt_x;
   assign w_sum      = w_acc_x + w_prod_x;

   assign w_ovf = P_SIGNED ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];

   // Signed overflow direction is given by the true sign bit w_sum[ACC_W].
   assign w_sat = !P_SIGNED     ? {ACC_W{1'b1}} :
                  w_sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                  {1'b0, {(ACC_W-1){1'b1}}};

   assign w_result = (w_ovf && P_SAT) ? w_sat : w_sum[ACC_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid  <= 1'b0;
         r_a      <= '0;
         r_acc    <= '0;
         r_shadow <= '0;
         r_active <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_valid <= valid_in;
         if (valid_in) begin
            r_a   <= a_in;
            r_acc <= w_result;
         end
         if (load_weight) r_shadow <= w_in;
         if (swap_weight) r_active <= r_shadow;
         if (valid_in && w_ovf) r_ovf <= 1'b1;
         else if (clear_ovf)    r_ovf <= 1'b0;
      end
   end

   assign valid_out = r_valid;
   assign a_out     = r_a;
   assign acc_out   = r_acc;
   assign w_out     = r_shadow;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe: five parameter configurations driven in lockstep,
// checked against an integer-arithmetic reference model.
module tb_systolic_pe;

   localparam int NCFG = 5;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic [7:0]  a_in;
   logic [23:0] acc_in;
   logic [7:0]  w_in;
   logic        load_weight;
   logic        swap_weight;
   logic        clear_ovf;

   logic [31:0] obs_acc   [NCFG];
   logic [7:0]  obs_a     [NCFG];
   logic [7:0]  obs_w     [NCFG];
   logic        obs_valid [NCFG];
   logic        obs_ovf   [NCFG];

   int cfg_w   [NCFG] = '{24, 16, 16, 16, 16};
   bit cfg_sgn [NCFG] = '{1, 1, 1, 0, 0};
   bit cfg_sat [NCFG] = '{1, 1, 0, 1, 0};

   // Reference state
   logic [31:0] exp_acc [NCFG];
   bit          exp_ovf [NCFG];
   logic [7:0]  exp_a;
   bit          exp_valid;
   logic [7:0]  exp_shadow;
   logic [7:0]  exp_active;

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [23:0] u0_acc;
   logic [15:0] u1_acc, u2_acc, u3_acc, u4_acc;

   systolic_pe #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .SATURATE(1)) u0 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .a_in(a_in), .acc_in(acc_in),
      .w_in(w_in), .load_weight(load_weight), .swap_weight(swap_weight), .clear_ovf(clear_ovf),
      .valid_out(obs_valid[0]), .a_out(obs_a[0]), .acc_out(u0_acc), .w_out(obs_w[0]), .ovf(obs_ovf[0]));
   systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1)) u1 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .a_in(a_in), .acc_in(acc_in[15:0]),
      .w_in(w_in), .load_weight(load_weight), .swap_weight(swap_weight), .clear_ovf(clear_ovf),
      .valid_out(obs_valid[1]), .a_out(obs_a[1]), .acc_out(u1_acc), .w_out(obs_w[1]), .ovf(obs_ovf[1]));
   systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0)) u2 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .a_in(a_in), .acc_in(acc_in[15:0]),
      .w_in(w_in), .load_weight(load_weight), .swap_weight(swap_weight), .clear_ovf(clear_ovf),
      .valid_out(obs_valid[2]), .a_out(obs_a[2]), .acc_out(u2_acc), .w_out(obs_w[2]), .ovf(obs_ovf[2]));
   systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) u3 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .a_in(a_in), .acc_in(acc_in[15:0]),
      .w_in(w_in), .load_weight(load_weight), .swap_weight(swap_weight), .clear_ovf(clear_ovf),
      .valid_out(obs_valid[3]), .a_out(obs_a[3]), .acc_out(u3_acc), .w_out(obs_w[3]), .ovf(obs_ovf[3]));
   systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(0)) u4 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .a_in(a_in), .acc_in(acc_in[15:0]),
      .w_in(w_in), .load_weight(load_weight), .swap_weight(swap_weight), .clear_ovf(clear_ovf),
      .valid_out(obs_valid[4]), .a_out(obs_a[4]), .acc_out(u4_acc), .w_out(obs_w[4]), .ovf(obs_ovf[4]));

   assign obs_acc[0] = {8'h00, u0_acc};
   assign obs_acc[1] = {16'h0000, u1_acc};
   assign obs_acc[2] = {16'h0000, u2_acc};
   assign obs_acc[3] = {16'h0000, u3_acc};
   assign obs_acc[4] = {16'h0000, u4_acc};

   // Exact integer MAC, then range check and clamp/wrap.
   function automatic logic [31:0] ref_mac(input int aw, input bit sgn, input bit sat,
                                           input logic [7:0] a, input logic [7:0] w,
                                           input logic [23:0] acc, output bit o);
      longint m, av, wv, cv, s, mx, mn;
      m  = longint'(1) << aw;
      av = longint'(a);
      wv = longint'(w);
      cv = longint'(acc) & (m - 1);
      if (sgn) begin
         if (av >= 128) av -= 256;
         if (wv >= 128) wv -= 256;
         if (cv >= m / 2) cv -= m;
         mx = m / 2 - 1;
         mn = -(m / 2);
      end else begin
         mx = m - 1;
         mn = 0;
      end
      s = cv + av * wv;
      o = (s > mx) || (s < mn);
      if (o && sat) s = (s > mx) ? mx : mn;
      return 32'(s & (m - 1));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < NCFG; c++) begin
         check($sformatf("u%0d.valid_out", c), 32'(obs_valid[c]), 32'(exp_valid));
         check($sformatf("u%0d.a_out", c),     32'(obs_a[c]),     32'(exp_a));
         check($sformatf("u%0d.w_out", c),     32'(obs_w[c]),     32'(exp_shadow));
         check($sformatf("u%0d.acc_out", c),   obs_acc[c],        exp_acc[c]);
         check($sformatf("u%0d.ovf", c),       32'(obs_ovf[c]),   32'(exp_ovf[c]));
      end
   endtask

   // Drive one cycle of inputs, advance the model, then sample after the edge.
   task automatic step(input bit rst, input bit vld, input bit ld, input bit sw, input bit clr,
                       input logic [7:0] a, input logic [7:0] w, input logic [23:0] acc);
      bit o;
      logic [31:0] r;
      reset = rst; valid_in = vld; load_weight = ld; swap_weight = sw; clear_ovf = clr;
      a_in = a; w_in = w; acc_in = acc;
      if (rst) begin
         exp_valid = 0; exp_a = '0; exp_shadow = '0; exp_active = '0;
         for (int c = 0; c < NCFG; c++) begin
            exp_acc[c] = '0;
            exp_ovf[c] = 0;
         end
      end else begin
         for (int c = 0; c < NCFG; c++) begin
            r = ref_mac(cfg_w[c], cfg_sgn[c], cfg_sat[c], a, exp_active, acc, o);
            if (vld) exp_acc[c] = r;
            if (vld && o) exp_ovf[c] = 1;
            else if (clr) exp_ovf[c] = 0;
         end
         exp_valid = vld;
         if (vld) exp_a = a;
         if (sw) exp_active = exp_shadow;
         if (ld) exp_shadow = w;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; a_in = '0; acc_in = '0; w_in = '0;
      load_weight = 1'b0; swap_weight = 1'b0; clear_ovf = 1'b0;
      exp_valid = 0; exp_a = '0; exp_shadow = '0; exp_active = '0;
      for (int c = 0; c < NCFG; c++) begin
         exp_acc[c] = '0;
         exp_ovf[c] = 0;
      end
      @(negedge clk);

      // Reset with every input active, then idle.
      step(1, 1, 1, 1, 1, 8'hA5, 8'h5A, 24'h123456);
      step(1, 1, 1, 1, 1, 8'hA5, 8'h5A, 24'h123456);
      check("rst.acc_out", obs_acc[0], 32'h0);
      step(0, 0, 0, 0, 0, 8'h00, 8'h00, 24'h0);
      step(0, 0, 0, 0, 0, 8'h00, 8'h00, 24'h0);

      // Load 5, swap, then (-3)*5 + 100.
      step(0, 0, 1, 0, 0, 8'h00, 8'd5, 24'h0);
      step(0, 0, 0, 1, 0, 8'h00, 8'h00, 24'h0);
      step(0, 1, 0, 0, 0, 8'hFD, 8'h00, 24'd100);
      check("ls.acc_out", obs_acc[0], 32'd85);
      check("ls.a_out", 32'(obs_a[0]), 32'hFD);
      check("ls.w_out", 32'(obs_w[0]), 32'd5);

      // Double buffer: load 7 while computing with 5; swap takes effect one sample later.
      step(0, 1, 1, 0, 0, 8'd2, 8'd7, 24'd0);
      check("db.first", obs_acc[0], 32'd10);
      step(0, 1, 0, 1, 0, 8'd2, 8'd0, 24'd0);
      check("db.swap_cycle", obs_acc[0], 32'd10);
      step(0, 1, 0, 0, 0, 8'd2, 8'd0, 24'd0);
      check("db.after_swap", obs_acc[0], 32'd14);

      // Signed overflow: -128 * -128 + 16384 = 32768.
      step(0, 0, 1, 0, 0, 8'h00, 8'h80, 24'h0);
      step(0, 0, 0, 1, 0, 8'h00, 8'h00, 24'h0);
      step(0, 1, 0, 0, 0, 8'h80, 8'h00, 24'h004000);
      check("sat.acc_out", obs_acc[1], 32'h7FFF);
      check("sat.ovf", 32'(obs_ovf[1]), 32'd1);
      check("wrap.acc_out", obs_acc[2], 32'h8000);
      check("wrap.ovf", 32'(obs_ovf[2]), 32'd1);
      step(0, 0, 0, 0, 1, 8'h00, 8'h00, 24'h0);
      check("clr.ovf", 32'(obs_ovf[1]), 32'd0);
      step(0, 1, 0, 0, 1, 8'h80, 8'h00, 24'h004000);
      check("set_wins.ovf", 32'(obs_ovf[2]), 32'd1);

      // Unsigned: 255*255 + 0xFFFF clamps to all-ones, then holds while idle.
      step(0, 0, 1, 0, 1, 8'h00, 8'hFF, 24'h0);
      step(0, 0, 0, 1, 0, 8'h00, 8'h00, 24'h0);
      step(0, 1, 0, 0, 0, 8'hFF, 8'h00, 24'h00FFFF);
      check("uns.acc_out", obs_acc[3], 32'hFFFF);
      check("uns.ovf", 32'(obs_ovf[3]), 32'd1);
      step(0, 0, 0, 0, 0, 8'h11, 8'h00, 24'h000123);
      check("uns.hold", obs_acc[3], 32'hFFFF);
      check("uns.valid_out", 32'(obs_valid[3]), 32'd0);

      // Reset mid-stream drops the in-flight sample.
      step(0, 1, 0, 0, 0, 8'h21, 8'h00, 24'h000777);
      step(1, 1, 0, 0, 0, 8'h22, 8'h00, 24'h000777);
      check("midrst.valid_out", 32'(obs_valid[0]), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, 8'($urandom), 8'($urandom), 24'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
